// File: rtl/scs8hd_oa_pipe_pkg.sv
// rtl/scs8hd_oa_pipe_pkg.sv - shared types and helpers for the OR-AND pipe
//
// Purpose: holds the per-channel OR-AND reduction used by scs8hd_oa_pipe.
// It is kept here so other decode blocks can reuse the same reduction.
// Ports: none (package).
package scs8hd_oa_pkg;

  // Widest OR operand slice oa_reduce accepts. Callers zero-extend narrower
  // slices, which does not change an OR reduction.
  localparam int MAX_N_IN = 256;

  // One lane of the array: (|a) & b1.
  function automatic logic oa_reduce(input logic [MAX_N_IN-1:0] a, input logic b1);
    return (|a) & b1;
  endfunction

endpackage

// File: rtl/scs8hd_oa_pipe_if.sv
// rtl/scs8hd_oa_pipe_if.sv - input/output stream bundle for the OR-AND pipe
//
// Purpose: groups the input beat (IN_VALID/IN_READY/A/B1) and the output
// beat (OUT_VALID/OUT_READY/X) of scs8hd_oa_pipe.
// Modports:
//   master - the environment: drives IN_VALID, A, B1, OUT_READY
//   slave  - the pipe: drives IN_READY, OUT_VALID, X
interface scs8hd_oa_pipe_if #(
  parameter int N_IN     = 4,
  parameter int CHANNELS = 1
);
  import scs8hd_oa_pkg::*;

  logic                     IN_VALID;
  logic                     IN_READY;
  logic [CHANNELS*N_IN-1:0] A;
  logic [CHANNELS-1:0]      B1;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic [CHANNELS-1:0]      X;

  modport master (
    output IN_VALID, A, B1, OUT_READY,
    input  IN_READY, OUT_VALID, X
  );

  modport slave (
    input  IN_VALID, A, B1, OUT_READY,
    output IN_READY, OUT_VALID, X
  );

endinterface

// File: rtl/scs8hd_oa_pipe_skid.sv
// rtl/scs8hd_oa_pipe_skid.sv - two-register valid/ready buffer
//
// Purpose: generic skid buffer built from a main (output) register and one
// skid register. in_ready_o comes straight from a flop, so there is no
// combinational path from out_ready_i to in_ready_o.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i/in_ready_o     input handshake, in_data_i payload (W bits)
//   out_valid_o/out_ready_i   output handshake, out_data_o payload (W bits)
module scs8hd_oa_skid #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  import scs8hd_oa_pkg::*;

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept;
  logic         pop;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  assign accept = in_valid_i & ~skid_valid_q;
  assign pop    = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        // Skid drains into main first; no new beat can arrive while it is
        // full because in_ready_o is low.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data_i;
        end
      end
    end else if (accept) begin
      // Main is stalled: park the beat in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/scs8hd_oa_pipe.sv
// rtl/scs8hd_oa_pipe.sv - pipelined, back-pressurable OR-AND array
//
// Purpose: per channel c, X[c] = (|A[c*N_IN +: N_IN]) & B1[c], registered
// with one cycle of latency behind a two-entry valid/ready buffer.
// Optional macro SCS8HD_OA_HITCNT_EN adds saturating per-channel hit
// counters that count popped beats with X[c]=1.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   bus          scs8hd_oa_pipe_if slave: IN_VALID/IN_READY/A/B1, OUT_VALID/OUT_READY/X
//   CNT_CLR      (macro only) clear all hit counters, wins over an increment
//   HIT_CNT      (macro only) per-channel count, channel c at [c*CNT_W +: CNT_W]
module scs8hd_oa_pipe #(
  parameter int N_IN     = 4,
  parameter int CHANNELS = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  scs8hd_oa_pipe_if.slave           bus
`ifdef SCS8HD_OA_HITCNT_EN
  ,
  input  logic                      CNT_CLR,
  output logic [CHANNELS*CNT_W-1:0] HIT_CNT
`endif
);
  import scs8hd_oa_pkg::*;

  logic [CHANNELS-1:0] beat;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign beat[c] = oa_reduce(MAX_N_IN'(bus.A[c*N_IN +: N_IN]), bus.B1[c]);
  end

  scs8hd_oa_skid #(.W(CHANNELS)) u_skid (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .in_valid_i  (bus.IN_VALID),
    .in_ready_o  (bus.IN_READY),
    .in_data_i   (beat),
    .out_valid_o (bus.OUT_VALID),
    .out_ready_i (bus.OUT_READY),
    .out_data_o  (bus.X)
  );

`ifdef SCS8HD_OA_HITCNT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                           pop;

  assign pop     = bus.OUT_VALID & bus.OUT_READY;
  assign HIT_CNT = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (pop) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.X[c] && (cnt_q[c] != MAX_CNT)) begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_scs8hd_oa_pipe.sv
// tb/tb_scs8hd_oa_pipe.sv - self-checking bench for scs8hd_oa_pipe
module tb_scs8hd_oa_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  scs8hd_oa_pipe_if #(.N_IN(4), .CHANNELS(1)) bus0 ();
  scs8hd_oa_pipe_if #(.N_IN(2), .CHANNELS(3)) bus1 ();

`ifdef SCS8HD_OA_HITCNT_EN
  logic        clr;
  logic [1:0]  hit0;
  logic [23:0] hit1;
`endif

  scs8hd_oa_pipe #(.N_IN(4), .CHANNELS(1), .CNT_W(2)) dut0 (
    .CLK     (clk),
    .RESET   (rst),
    .bus     (bus0.slave)
`ifdef SCS8HD_OA_HITCNT_EN
    ,
    .CNT_CLR (clr),
    .HIT_CNT (hit0)
`endif
  );

  scs8hd_oa_pipe #(.N_IN(2), .CHANNELS(3), .CNT_W(8)) dut1 (
    .CLK     (clk),
    .RESET   (rst),
    .bus     (bus1.slave)
`ifdef SCS8HD_OA_HITCNT_EN
    ,
    .CNT_CLR (clr),
    .HIT_CNT (hit1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each pipe is a two-deep FIFO of expected results,
  // ready whenever it is not full at the start of the cycle.
  logic       q0[$];
  logic [2:0] q1[$];
  logic       log0[$];
  int         cnt0;
  int         cnt1[3];

  function automatic logic ref0(input logic [3:0] a, input logic b);
    return (a != 4'd0) && b;
  endfunction

  function automatic logic [2:0] ref1(input logic [5:0] a, input logic [2:0] b);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = b[c] && (((a >> (2 * c)) & 6'd3) != 6'd0);
    return r;
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    bit         acc0, acc1, pop0, pop1;
    logic       e0, pv0;
    logic [2:0] e1, pv1;
    acc0 = bus0.IN_VALID && (q0.size() < 2);
    acc1 = bus1.IN_VALID && (q1.size() < 2);
    pop0 = (q0.size() > 0) && bus0.OUT_READY;
    pop1 = (q1.size() > 0) && bus1.OUT_READY;
    e0   = ref0(bus0.A, bus0.B1[0]);
    e1   = ref1(bus1.A, bus1.B1);
    if (bus0.OUT_VALID && bus0.OUT_READY) log0.push_back(bus0.X[0]);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      cnt0 = 0;
      for (int c = 0; c < 3; c++) cnt1[c] = 0;
    end else begin
      pv0 = 1'b0;
      pv1 = 3'b000;
      if (pop0) pv0 = q0.pop_front();
      if (pop1) pv1 = q1.pop_front();
      if (acc0) q0.push_back(e0);
      if (acc1) q1.push_back(e1);
`ifdef SCS8HD_OA_HITCNT_EN
      if (clr) begin
        cnt0 = 0;
        for (int c = 0; c < 3; c++) cnt1[c] = 0;
      end else begin
        if (pop0 && pv0 && cnt0 < 3) cnt0++;
        for (int c = 0; c < 3; c++) if (pop1 && pv1[c] && cnt1[c] < 255) cnt1[c]++;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus0.OUT_VALID !== 1'b0 || bus0.X !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0 got valid=%b x=%b want 0 0", bus0.OUT_VALID, bus0.X);
    end
    checks++;
    if (bus1.OUT_VALID !== 1'b0 || bus1.X !== 3'b000) begin
      failures++;
      $display("FAIL reset_dut1 got valid=%b x=%b want 0 000", bus1.OUT_VALID, bus1.X);
    end
`ifdef SCS8HD_OA_HITCNT_EN
    checks++;
    if (hit0 !== 2'd0 || hit1 !== 24'd0) begin
      failures++;
      $display("FAIL reset_hitcnt got %0d/%h want 0/0", hit0, hit1);
    end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if (bus0.IN_READY !== 1'b1 || bus1.IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b %b want 1 1", bus0.IN_READY, bus1.IN_READY);
    end
  endtask

  task automatic test_basic();
    logic [3:0] av[3];
    logic       bv[3];
    logic       xv[3];
    av = '{4'b0100, 4'b0000, 4'b1111};
    bv = '{1'b1, 1'b1, 1'b0};
    xv = '{1'b1, 1'b0, 1'b0};
    bus0.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.IN_VALID = 1'b1;
      bus0.A        = av[i];
      bus0.B1       = bv[i];
      tick();
      checks++;
      if (bus0.OUT_VALID !== 1'b1 || bus0.X !== xv[i]) begin
        failures++;
        $display("FAIL basic_%0d got valid=%b x=%b want 1 %b", i, bus0.OUT_VALID, bus0.X, xv[i]);
      end
    end
    bus0.IN_VALID = 1'b0;
    tick();
    checks++;
    if (bus0.OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain got valid=%b want 0", bus0.OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    bus0.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.IN_VALID = 1'b1;
      bus0.A        = 4'($urandom_range(0, 15));
      bus0.B1       = 1'($urandom_range(0, 1));
      e             = ref0(bus0.A, bus0.B1[0]);
      tick();
      checks++;
      if (bus0.OUT_VALID !== 1'b1 || bus0.X !== e || bus0.IN_READY !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d got valid=%b x=%b rdy=%b want 1 %b 1",
                 i, bus0.OUT_VALID, bus0.X, bus0.IN_READY, e);
      end
    end
    bus0.IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] av[3];
    logic       bv[3];
    logic       want_rdy[3];
    av       = '{4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    bv       = '{1'b1, 1'b0, 1'b1};
    want_rdy = '{1'b1, 1'b0, 1'b0};
    log0.delete();
    bus0.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.IN_VALID = 1'b1;
      bus0.A        = av[i];
      bus0.B1       = bv[i];
      tick();
      checks++;
      if (bus0.IN_READY !== want_rdy[i] || bus0.OUT_VALID !== 1'b1 || bus0.X !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall_%0d got rdy=%b valid=%b x=%b want %b 1 1",
                 i, bus0.IN_READY, bus0.OUT_VALID, bus0.X, want_rdy[i]);
      end
    end
    bus0.OUT_READY = 1'b1;
    tick();
    checks++;
    if (bus0.X !== 1'b0 || bus0.IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got x=%b rdy=%b want 0 1", bus0.X, bus0.IN_READY);
    end
    tick();
    bus0.IN_VALID = 1'b0;
    tick();
    tick();
    checks++;
    if (log0.size() != 3) begin
      failures++;
      $display("FAIL bp_count got %0d beats want 3", log0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log0[i] !== bv[i]) begin
          failures++;
          $display("FAIL bp_order_%0d got %b want %b", i, log0[i], bv[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus0.IN_VALID  = 1'($urandom_range(0, 1));
      bus0.A         = 4'($urandom);
      bus0.B1        = 1'($urandom);
      bus0.OUT_READY = ($urandom_range(0, 9) < 7);
      bus1.IN_VALID  = 1'($urandom_range(0, 1));
      bus1.A         = 6'($urandom);
      bus1.B1        = 3'($urandom);
      bus1.OUT_READY = ($urandom_range(0, 9) < 6);
      tick();
      checks++;
      if (bus0.OUT_VALID !== (q0.size() > 0) || bus0.IN_READY !== (q0.size() < 2) ||
          (q0.size() > 0 && bus0.X !== q0[0])) begin
        failures++;
        $display("FAIL rand0_%0d got valid=%b rdy=%b x=%b want depth %0d", i,
                 bus0.OUT_VALID, bus0.IN_READY, bus0.X, q0.size());
      end
      checks++;
      if (bus1.OUT_VALID !== (q1.size() > 0) || bus1.IN_READY !== (q1.size() < 2) ||
          (q1.size() > 0 && bus1.X !== q1[0])) begin
        failures++;
        $display("FAIL rand1_%0d got valid=%b rdy=%b x=%b want depth %0d head %b", i,
                 bus1.OUT_VALID, bus1.IN_READY, bus1.X, q1.size(), (q1.size() > 0) ? q1[0] : 3'b000);
      end
`ifdef SCS8HD_OA_HITCNT_EN
      checks++;
      if (hit0 !== 2'(cnt0) || hit1 !== {8'(cnt1[2]), 8'(cnt1[1]), 8'(cnt1[0])}) begin
        failures++;
        $display("FAIL rand_hitcnt_%0d got %0d/%h want %0d/%h", i, hit0, hit1,
                 cnt0, {8'(cnt1[2]), 8'(cnt1[1]), 8'(cnt1[0])});
      end
`endif
    end
    bus0.IN_VALID  = 1'b0;
    bus1.IN_VALID  = 1'b0;
    bus0.OUT_READY = 1'b1;
    bus1.OUT_READY = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_multi_reset();
    bus1.OUT_READY = 1'b1;
    bus1.IN_VALID  = 1'b1;
    bus1.A         = 6'b10_00_01;
    bus1.B1        = 3'b101;
    tick();
    checks++;
    if (bus1.OUT_VALID !== 1'b1 || bus1.X !== 3'b101) begin
      failures++;
      $display("FAIL multi_lane got valid=%b x=%b want 1 101", bus1.OUT_VALID, bus1.X);
    end
    bus1.OUT_READY = 1'b0;
    bus1.A         = 6'b11_11_11;
    bus1.B1        = 3'b111;
    tick();
    tick();
    checks++;
    if (bus1.IN_READY !== 1'b0) begin
      failures++;
      $display("FAIL multi_skid_full got rdy=%b want 0", bus1.IN_READY);
    end
    bus1.IN_VALID = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bus1.OUT_VALID !== 1'b0 || bus1.IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL multi_flush got valid=%b rdy=%b want 0 1", bus1.OUT_VALID, bus1.IN_READY);
    end
    rst = 1'b0;
    bus1.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus1.OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL multi_stale_%0d got valid=%b x=%b want 0", i, bus1.OUT_VALID, bus1.X);
      end
    end
  endtask

`ifdef SCS8HD_OA_HITCNT_EN
  task automatic test_hitcnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus0.OUT_READY = 1'b1;
    bus0.IN_VALID  = 1'b1;
    bus0.A         = 4'b0010;
    bus0.B1        = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus0.IN_VALID = 1'b0;
    tick();
    checks++;
    if (hit0 !== 2'd3) begin
      failures++;
      $display("FAIL hitcnt_sat got %0d want 3", hit0);
    end
    bus0.IN_VALID = 1'b1;
    tick();
    bus0.IN_VALID = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (hit0 !== 2'd0 || bus0.OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL hitcnt_clr_pop got %0d valid=%b want 0 0", hit0, bus0.OUT_VALID);
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    bus0.IN_VALID  = 1'b0;
    bus0.A         = '0;
    bus0.B1        = '0;
    bus0.OUT_READY = 1'b0;
    bus1.IN_VALID  = 1'b0;
    bus1.A         = '0;
    bus1.B1        = '0;
    bus1.OUT_READY = 1'b0;
`ifdef SCS8HD_OA_HITCNT_EN
    clr = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_multi_reset();
`ifdef SCS8HD_OA_HITCNT_EN
    test_hitcnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
